// File: rtl/halt_checker.sv
// Purpose : self-check harness for a CPU core; compares the data register against a small
//           table of expected results at every rising edge of the CPU halt flag.
// Latency : the verdict (pass/fail/timeout) and fail_* capture appear 1 clk after the deciding edge.
// Backpressure: none; halt events are sampled every clock and never stalled.
//
// Ports
//   clk, reset     : rising-edge clock, asynchronous active-low reset
//   start          : arm/re-arm pulse; clears index, cycle_count and fail_* and enters RUN
//   dr, cr, pc     : CPU data register, control register (bit HLT_BIT = halt), program counter
//   exp_we/addr/data : expected-table write port, ignored while RUN
//   exp_count      : number of valid table entries (values above DEPTH are treated as DEPTH)
//   busy/pass/fail/timeout : mutually exclusive state flags
//   fail_index/fail_dr/fail_pc : snapshot of the first mismatching halt
//   cycle_count    : clocks spent in RUN since arm, saturating
//
// Build option: define HALT_CHECKER_TIMEOUT_EN to enable the RUN watchdog (TIMEOUT_CYCLES).
// Without it the timeout flag is tied low and RUN lasts until a halt outcome.

`ifndef BIT_CR_HLT
`define BIT_CR_HLT 0
`endif

module halt_checker #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          PC_WIDTH       = 16,
    parameter int          CR_WIDTH       = 8,
    parameter int          HLT_BIT        = `BIT_CR_HLT,
    parameter int          DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int         IDX_W          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int         CNT_W          = IDX_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dr,
    input  logic [CR_WIDTH-1:0]   cr,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic                  exp_we,
    input  logic [IDX_W-1:0]      exp_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [CNT_W-1:0]      exp_count,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [IDX_W-1:0]      fail_index,
    output logic [DATA_WIDTH-1:0] fail_dr,
    output logic [PC_WIDTH-1:0]   fail_pc,
    output logic [31:0]           cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Expected-result table; deliberately not reset so a test program can load it once
    // and survive a CPU/checker reset.
    logic [DATA_WIDTH-1:0] exp_tbl [DEPTH];

    logic [IDX_W-1:0] index;
    logic             halt_prev;
    logic             halt_edge;
    logic [CNT_W-1:0] cnt_eff;
    logic             dr_match;
    logic             at_last;
    logic             to_hit;

    // ------------------------------------------------------------------
    // Halt edge detection. halt_prev tracks cr every cycle regardless of
    // state, so a flag already high when the checker is armed never counts.
    // ------------------------------------------------------------------
    assign halt_edge = cr[HLT_BIT] & ~halt_prev;

    // Clamp the entry count to the physical table size.
    assign cnt_eff  = (exp_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : exp_count;

    // Full-width bit equality: signed and unsigned encodings compare identically.
    assign dr_match = (dr == exp_tbl[index]);

    // Only meaningful when cnt_eff != 0; that case is decided before this is used.
    assign at_last  = ({1'b0, index} == (cnt_eff - CNT_W'(1)));

`ifdef HALT_CHECKER_TIMEOUT_EN
    // cycle_count still holds the pre-increment value, so the last allowed RUN
    // cycle is the one where it reads TIMEOUT_CYCLES-1.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    assign to_hit = (cycle_count == TO_LAST);
`else
    // Watchdog absent: parameter retained only so both builds share one interface.
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign to_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. start wins from every state (arm or re-arm) and
    // masks any halt edge in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cnt_eff == '0) begin
                        // Nothing to check: immediate pass on the first RUN cycle.
                        state_nxt = ST_PASS;
                    end else if (halt_edge) begin
                        // A halt outcome takes priority over the watchdog.
                        if (!dr_match) begin
                            state_nxt = ST_FAIL;
                        end else if (at_last) begin
                            state_nxt = ST_PASS;
                        end else begin
                            state_nxt = ST_RUN;
                        end
                    end else if (to_hit) begin
                        state_nxt = ST_TIMEOUT;
                    end
                end
                // IDLE and the terminal states hold until start or reset.
                default: state_nxt = state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (flags come straight from the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        busy    = 1'b0;
        pass    = 1'b0;
        fail    = 1'b0;
        timeout = 1'b0;
        case (state)
            ST_RUN:     busy    = 1'b1;
            ST_PASS:    pass    = 1'b1;
            ST_FAIL:    fail    = 1'b1;
`ifdef HALT_CHECKER_TIMEOUT_EN
            ST_TIMEOUT: timeout = 1'b1;
`endif
            default:    ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: halt history, entry index, RUN cycle counter, fail capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_prev   <= 1'b0;
            index       <= '0;
            cycle_count <= '0;
            fail_index  <= '0;
            fail_dr     <= '0;
            fail_pc     <= '0;
        end else begin
            halt_prev <= cr[HLT_BIT];
            if (start) begin
                index       <= '0;
                cycle_count <= '0;
                fail_index  <= '0;
                fail_dr     <= '0;
                fail_pc     <= '0;
            end else if (state == ST_RUN) begin
                // Every RUN cycle counts, including the one that decides the outcome.
                if (cycle_count != 32'hFFFF_FFFF) begin
                    cycle_count <= cycle_count + 32'd1;
                end
                if ((cnt_eff != '0) && halt_edge) begin
                    if (dr_match) begin
                        if (!at_last) begin
                            index <= index + IDX_W'(1);
                        end
                    end else begin
                        fail_index <= index;
                        fail_dr    <= dr;
                        fail_pc    <= pc;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Expected table write port; locked while a check is running so the
    // reference cannot change under the comparison.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (exp_we && (state != ST_RUN)) begin
            exp_tbl[exp_addr] <= exp_data;
        end
    end

endmodule

// File: doc/halt_checker.md
HALT_CHECKER -- requirements
Module: halt_checker

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the data register being checked.
- REQ-002 SHALL have parameter PC_WIDTH, default 16, program-counter width.
- REQ-003 SHALL have parameter CR_WIDTH, default 8, control-register width.
- REQ-004 SHALL have parameter HLT_BIT, default `BIT_CR_HLT, index of the halt flag in cr.
- REQ-005 SHALL have parameter DEPTH, default 4, number of expected-result entries (power of 2, 1..256).
- REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1000000, watchdog limit in clocks.
- REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge.
- REQ-008 reset  in  1  asynchronous, active-low reset.
- REQ-009 start  in  1  arm pulse; clears counters and index.
- REQ-010 dr  in  DATA_WIDTH  CPU data register under test.
- REQ-011 cr  in  CR_WIDTH  CPU control register; bit HLT_BIT = halt.
- REQ-012 pc  in  PC_WIDTH  CPU program counter.
- REQ-013 exp_we  in  1  expected-table write enable.
- REQ-014 exp_addr  in  log2(DEPTH)  table write address.
- REQ-015 exp_data  in  DATA_WIDTH  expected value.
- REQ-016 exp_count  in  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
- REQ-017 busy/pass/fail/timeout  out  1 each  state flags, mutually exclusive.
- REQ-018 fail_index  out  log2(DEPTH)  entry that mismatched; fail_dr  out  DATA_WIDTH; fail_pc  out  PC_WIDTH.
- REQ-019 cycle_count  out  32  clocks since arm, saturating at 2^32-1.

Function
- REQ-020 SHALL implement states IDLE, RUN, PASS, FAIL, TIMEOUT; busy=1 only in RUN.
- REQ-021 Halt event SHALL be a rising edge: cr[HLT_BIT]=1 and registered previous value=0; previous value updated every cycle in all states.
- REQ-022 IDLE/PASS/FAIL/TIMEOUT + start=1 -> RUN next cycle; index, cycle_count, fail_* cleared; a halt edge in the start cycle is ignored.
- REQ-023 start asserted in RUN SHALL restart RUN with the same clearing (re-arm).
- REQ-024 RUN, halt edge, dr == table[index]: index = exp_count-1 -> PASS, else index+1, stay in RUN.
- REQ-025 RUN, halt edge, dr != table[index] -> FAIL; capture index, dr, pc in the same edge's cycle (1-clock latency to outputs).
- REQ-026 RUN with exp_count=0 SHALL go to PASS on the first RUN cycle; exp_count>DEPTH SHALL be treated as DEPTH.
- REQ-027 cycle_count SHALL increment each RUN cycle, hold in all other states.
- REQ-028 Table writes SHALL be accepted in any state except RUN; writes during RUN ignored; table contents not cleared by reset.
- REQ-029 Terminal states SHALL hold until start or reset; halt edges there ignored.
- REQ-030 Comparison SHALL be full-width bit equality (signed and unsigned are identical).

Reset
- REQ-031 reset=0 SHALL asynchronously force IDLE, busy/pass/fail/timeout=0, fail_index/fail_dr/fail_pc=0, cycle_count=0, index=0, previous halt=0.
- REQ-032 reset mid-RUN SHALL abandon the check; no flag asserted until the next start.

Configuration
- REQ-033 Macro HALT_CHECKER_TIMEOUT_EN defined: RUN with cycle_count = TIMEOUT_CYCLES-1 and no halt edge -> TIMEOUT; a halt edge in the same cycle takes priority.
- REQ-034 Macro undefined: no watchdog logic; timeout output tied 0; RUN lasts until a halt outcome.

Verification
- REQ-035 Table[0]=32'hFFFFFFFC, exp_count=1, start, halt rises at cycle 50 with dr=-4 -> pass=1 next cycle, cycle_count=50.
- REQ-036 Same setup, dr=32'h00000005 at halt -> fail=1, fail_index=0, fail_dr=5, fail_pc = pc at halt.
- REQ-037 Table {1,2,3}, exp_count=3, three halt pulses dr=1,2,3 -> pass after third; dr=1,7 -> fail, fail_index=1.
- REQ-038 TIMEOUT_EN, TIMEOUT_CYCLES=100, no halt -> timeout=1 after 100 RUN cycles; halt edge on cycle 100 with matching dr -> pass, timeout=0.
- REQ-039 halt held high through start, never falls -> no event, stays RUN; reset=0 at cycle 30 of RUN -> IDLE, all outputs 0 immediately.
- REQ-040 exp_count=0, start -> pass on next cycle; exp_we during RUN changes nothing after re-arm compare.
